// File: rtl/param_updown_counter.sv
// Up/down/bounce counter with wrap or saturate at MAX_VAL and a sticky ovf flag.
// Latency: out/dir/ovf update one edge after inputs; tc is combinational.
// Backpressure: none, en gates counting each cycle and load always wins.
module param_updown_counter #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 2**WIDTH-1,
  parameter bit WRAP    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             dir,
  output logic             tc,
  output logic             ovf
);

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DN   = 2'b01;
  localparam logic [1:0] MODE_BNC  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic             counting;
  logic             going_up;
  logic             at_term;
  logic             ovf_set;
  logic [WIDTH-1:0] out_nxt;
  logic             dir_nxt;
  logic             ovf_nxt;

  assign counting = en & ~load & (mode != MODE_HOLD);
  assign going_up = (mode == MODE_UP) | ((mode == MODE_BNC) & dir);
  assign at_term  = going_up ? (out == MAXV) : (out == ZERO);
  assign tc       = ~rst & counting & at_term;
  // Bounce turn-arounds are not overflows; only up/down terminal events count.
  assign ovf_set  = tc & ~mode[1];

  always_comb begin
    out_nxt = out;
    dir_nxt = dir;
    if (load) begin
      out_nxt = (in > MAXV) ? MAXV : in;
    end else if (counting) begin
      case (mode)
        MODE_UP: begin
          dir_nxt = 1'b1;
          out_nxt = at_term ? (WRAP ? ZERO : MAXV) : out + ONE;
        end
        MODE_DN: begin
          dir_nxt = 1'b0;
          out_nxt = at_term ? (WRAP ? MAXV : ZERO) : out - ONE;
        end
        MODE_BNC: begin
          if (at_term) begin
            dir_nxt = ~dir;
            out_nxt = dir ? MAXV - ONE : ONE;
          end else begin
            out_nxt = dir ? out + ONE : out - ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ovf_nxt = ovf;
    if (load)
      ovf_nxt = 1'b0;
    else if (ovf_set)
      ovf_nxt = 1'b1;
    else if (clr_ovf)
      ovf_nxt = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
      dir <= 1'b1;
      ovf <= 1'b0;
    end else begin
      out <= out_nxt;
      dir <= dir_nxt;
      ovf <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench: WIDTH=4, MAX_VAL=9, one wrapping and one saturating instance
// sharing all inputs.
module tb_param_updown_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [1:0] mode;
  logic [3:0] in;
  logic       clr_ovf;
  logic [3:0] out0, out1;
  logic       dir0, dir1, tc0, tc1, ovf0, ovf1;

  int errors = 0;
  int checks = 0;

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b1)) u_wrap (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .in(in),
    .clr_ovf(clr_ovf), .out(out0), .dir(dir0), .tc(tc0), .ovf(ovf0)
  );

  param_updown_counter #(.WIDTH(4), .MAX_VAL(9), .WRAP(1'b0)) u_sat (
    .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode), .in(in),
    .clr_ovf(clr_ovf), .out(out1), .dir(dir1), .tc(tc1), .ovf(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int prev;
  int pdir;
  int eo;
  int ed;

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; mode = 2'b01; in = 4'd0; clr_ovf = 1'b0;
    #1;
    check("rst_out", int'(out0), 0);
    check("rst_dir", int'(dir0), 1);
    check("rst_ovf", int'(ovf0), 0);
    check("rst_tc", int'(tc0), 0);
    tick();
    tick();
    rst = 1'b0;

    // count up with wrap
    mode = 2'b00; en = 1'b1;
    prev = 0;
    for (int k = 1; k <= 12; k++) begin
      check("up_tc", int'(tc0), (prev == 9) ? 1 : 0);
      tick();
      check("up_out", int'(out0), k % 10);
      check("up_ovf", int'(ovf0), (k >= 10) ? 1 : 0);
      prev = k % 10;
    end

    // clamped load then count down with wrap
    en = 1'b0; load = 1'b1; in = 4'hF; mode = 2'b01;
    tick();
    check("ld_clamp", int'(out0), 9);
    check("ld_ovf", int'(ovf0), 0);
    load = 1'b0; en = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      check("dn_out", int'(out0), (19 - k) % 10);
      check("dn_ovf", int'(ovf0), (k >= 10) ? 1 : 0);
      check("dn_dir", int'(dir0), 0);
    end

    // saturating instance
    en = 1'b0; load = 1'b1; in = 4'd8; mode = 2'b00;
    tick();
    check("sat_ld", int'(out1), 8);
    check("sat_ld_ovf", int'(ovf1), 0);
    load = 1'b0; en = 1'b1;
    check("sat_tc0", int'(tc1), 0);
    tick();
    check("sat_out1", int'(out1), 9);
    check("sat_ovf1", int'(ovf1), 0);
    check("sat_tc1", int'(tc1), 1);
    tick();
    check("sat_out2", int'(out1), 9);
    check("sat_ovf2", int'(ovf1), 1);
    tick();
    check("sat_out3", int'(out1), 9);
    check("sat_ovf3", int'(ovf1), 1);
    en = 1'b0; clr_ovf = 1'b1;
    tick();
    check("clr_ovf", int'(ovf1), 0);
    check("clr_out", int'(out1), 9);
    clr_ovf = 1'b0;

    // set beats clear on the same edge
    load = 1'b1; in = 4'd9;
    tick();
    load = 1'b0; en = 1'b1; clr_ovf = 1'b1;
    tick();
    check("setwin_out", int'(out0), 0);
    check("setwin_ovf", int'(ovf0), 1);
    clr_ovf = 1'b0; en = 1'b0;

    // bounce from 0 going up
    load = 1'b1; in = 4'd0; mode = 2'b10;
    tick();
    check("bnc_start", int'(out0), 0);
    check("bnc_dir0", int'(dir0), 1);
    check("bnc_ovf0", int'(ovf0), 0);
    load = 1'b0; en = 1'b1;
    prev = 0; pdir = 1;
    for (int k = 1; k <= 20; k++) begin
      check("bnc_tc", int'(tc0), ((pdir == 1 && prev == 9) || (pdir == 0 && prev == 0)) ? 1 : 0);
      tick();
      eo = (k <= 9) ? k : ((k <= 18) ? 18 - k : k - 18);
      ed = (k <= 9 || k >= 19) ? 1 : 0;
      check("bnc_out", int'(out0), eo);
      check("bnc_dir", int'(dir0), ed);
      check("bnc_ovf", int'(ovf0), 0);
      check("bnc_sat_out", int'(out1), eo);
      prev = eo; pdir = ed;
    end

    // async reset mid-count
    en = 1'b0; load = 1'b1; in = 4'd0; mode = 2'b01;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check("pre_out", int'(out0), 9);
    check("pre_ovf", int'(ovf0), 1);
    for (int k = 0; k < 4; k++) tick();
    check("pre_rst_out", int'(out0), 5);
    #3 rst = 1'b1;
    #1;
    check("arst_out", int'(out0), 0);
    check("arst_dir", int'(dir0), 1);
    check("arst_ovf", int'(ovf0), 0);
    check("arst_tc", int'(tc0), 0);
    tick();
    check("arst_hold", int'(out0), 0);
    rst = 1'b0;
    tick();
    check("post_rst", int'(out0), 9);
    load = 1'b1; in = 4'd3; mode = 2'b00; en = 1'b1;
    tick();
    check("ld_wins", int'(out0), 3);
    check("ld_clr_ovf", int'(ovf0), 0);

    // hold via en=0 and via mode=11
    load = 1'b0; en = 1'b0; mode = 2'b00;
    for (int k = 0; k < 3; k++) begin
      check("hold_en_tc", int'(tc0), 0);
      tick();
      check("hold_en_out", int'(out0), 3);
    end
    en = 1'b1; mode = 2'b11;
    for (int k = 0; k < 2; k++) begin
      check("hold_md_tc", int'(tc0), 0);
      tick();
      check("hold_md_out", int'(out0), 3);
    end
    check("hold_dir", int'(dir0), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
